accessory_adapter: RTL

ACCESSORY_ADAPTER -- requirements
Module: accessory_adapter

---
 rtl/accessory_adapter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/accessory_adapter.sv
// accessory_adapter
//   Bridges a host-side character stream to the computer's serial accessory
//   lines, in two independent directions:
//   - Reader: host characters are buffered in a small FIFO. While the reader
//     is ACTIVE, each PL19_SHIFT_CMD_M20 cycle consumes one bit of the FIFO
//     head, MSB first. The bit is presented on PL19_INPUT.
//   - Punch: each PL20_OUTPUT_SHIFT cycle samples PL20_OUTPUT into a shift
//     register. Every CHAR_BITS bits, the assembled character is offered to
//     the host through a one-entry holding register.
//
// Ports
//   CLOCK, rst                      clock, synchronous active-high reset
//   PL19_START_INPUT/STOP_INPUT     reader start/stop requests (stop wins)
//   PL19_SHIFT_CMD_M20              reader bit-consume strobe
//   PL19_INPUT                      serial bit presented to the computer
//   PL20_OUTPUT, PL20_OUTPUT_SHIFT  punch serial bit and its sample strobe
//   host_in_data/valid/ready        host -> reader FIFO handshake
//   host_out_data/valid/ready       punch -> host handshake
//   clear_flags                     clears the sticky underrun/overflow flags
//   reader_active, underrun, overflow  status
module accessory_adapter #(
  parameter int CHAR_BITS  = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  input  logic                 PL19_START_INPUT,
  input  logic                 PL19_STOP_INPUT,
  input  logic                 PL19_SHIFT_CMD_M20,
  output logic                 PL19_INPUT,
  input  logic                 PL20_OUTPUT,
  input  logic                 PL20_OUTPUT_SHIFT,
  input  logic [CHAR_BITS-1:0] host_in_data,
  input  logic                 host_in_valid,
  output logic                 host_in_ready,
  output logic [CHAR_BITS-1:0] host_out_data,
  output logic                 host_out_valid,
  input  logic                 host_out_ready,
  input  logic                 clear_flags,
  output logic                 reader_active,
  output logic                 underrun,
  output logic                 overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = (CHAR_BITS > 1) ? $clog2(CHAR_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CHAR_BITS - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } rd_state_e;

  // Reader state
  rd_state_e            state_q, state_d;
  logic [CHAR_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic                 underrun_q, underrun_d;
  logic                 fifo_empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 underrun_set_s;
  logic [CHAR_BITS-1:0] head_s;

  // Punch state. The shift register keeps only CHAR_BITS-1 bits; the final
  // bit comes straight from PL20_OUTPUT when the character completes.
  logic [CHAR_BITS-2:0] osr_q, osr_d;
  logic [BIT_W-1:0]     obitcnt_q, obitcnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [CHAR_BITS-1:0] out_data_q, out_data_d;
  logic                 overflow_q, overflow_d;
  logic [CHAR_BITS-1:0] shifted_s;
  logic                 complete_s;
  logic                 drain_s;
  logic                 ovf_set_s;

  assign fifo_empty_s  = (count_q == {CNT_W{1'b0}});
  assign head_s        = mem_q[rd_ptr_q];
  assign host_in_ready = (count_q < DEPTH_CNT);
  assign push_s        = host_in_valid & host_in_ready;

  // Reader FSM next state, bit counter and FIFO pop decision
  always_comb begin
    state_d        = state_q;
    bitcnt_d       = bitcnt_q;
    pop_s          = 1'b0;
    underrun_set_s = 1'b0;
    if ((state_q == ST_ACTIVE) && PL19_SHIFT_CMD_M20 && fifo_empty_s) begin
      underrun_set_s = 1'b1;
    end else begin
      underrun_set_s = 1'b0;
    end
    if (PL19_STOP_INPUT) begin
      // A partially shifted head is discarded; unstarted characters stay.
      state_d  = ST_IDLE;
      bitcnt_d = {BIT_W{1'b0}};
      pop_s    = (bitcnt_q != {BIT_W{1'b0}});
    end else if (state_q == ST_ACTIVE) begin
      if (PL19_SHIFT_CMD_M20 && !fifo_empty_s) begin
        if (bitcnt_q == LAST_BIT) begin
          bitcnt_d = {BIT_W{1'b0}};
          pop_s    = 1'b1;
        end else begin
          bitcnt_d = bitcnt_q + BIT_W'(1);
        end
      end else begin
        bitcnt_d = bitcnt_q;
      end
    end else if (PL19_START_INPUT) begin
      state_d = ST_ACTIVE;
    end else begin
      state_d = state_q;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (underrun_set_s) begin
      underrun_d = 1'b1;
    end else if (clear_flags) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Serial bit toward the computer: current head bit, MSB first
  always_comb begin
    if ((state_q == ST_ACTIVE) && !fifo_empty_s) begin
      PL19_INPUT = head_s[LAST_BIT - bitcnt_q];
    end else begin
      PL19_INPUT = 1'b0;
    end
  end

  // Punch assembly, holding register load/drain and overflow detection
  always_comb begin
    shifted_s   = {osr_q, PL20_OUTPUT};
    drain_s     = out_valid_q & host_out_ready;
    complete_s  = PL20_OUTPUT_SHIFT & (obitcnt_q == LAST_BIT);
    // Draining in the same cycle frees the register for the new character.
    ovf_set_s   = complete_s & out_valid_q & ~drain_s;
    osr_d       = osr_q;
    obitcnt_d   = obitcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (PL20_OUTPUT_SHIFT) begin
      osr_d     = shifted_s[CHAR_BITS-2:0];
      obitcnt_d = complete_s ? {BIT_W{1'b0}} : (obitcnt_q + BIT_W'(1));
    end else begin
      osr_d     = osr_q;
      obitcnt_d = obitcnt_q;
    end
    if (complete_s && !ovf_set_s) begin
      out_valid_d = 1'b1;
      out_data_d  = shifted_s;
    end else if (drain_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (clear_flags) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and status registers for both paths
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      bitcnt_q    <= {BIT_W{1'b0}};
      underrun_q  <= 1'b0;
      osr_q       <= {(CHAR_BITS-1){1'b0}};
      obitcnt_q   <= {BIT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {CHAR_BITS{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      bitcnt_q    <= bitcnt_d;
      underrun_q  <= underrun_d;
      osr_q       <= osr_d;
      obitcnt_q   <= obitcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge CLOCK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= host_in_data;
    end
  end

  assign reader_active  = (state_q == ST_ACTIVE);
  assign underrun       = underrun_q;
  assign overflow       = overflow_q;
  assign host_out_valid = out_valid_q;
  assign host_out_data  = out_data_q;

endmodule
